// File: rtl/dbg_bus_pkg.sv
// Shared definitions for the debug-bus responder: address map, CMD bit
// positions and the bus word/address types.
package dbg_bus_pkg;

    typedef logic [15:0] dbg_addr_t;
    typedef logic [31:0] dbg_word_t;

    // Fixed register addresses at the bottom of the debug address space
    localparam dbg_addr_t ADDR_MON0     = 16'h0000;
    localparam dbg_addr_t ADDR_MON1     = 16'h0001;
    localparam dbg_addr_t ADDR_CTRL     = 16'h0002;
    localparam dbg_addr_t ADDR_CMD      = 16'h0003;
    localparam dbg_addr_t ADDR_SNAP0    = 16'h0004;
    localparam dbg_addr_t ADDR_SNAP1    = 16'h0005;
    localparam dbg_addr_t ADDR_STATUS   = 16'h0006;
    localparam dbg_addr_t ADDR_EVT_CNT  = 16'h0007;
    localparam dbg_addr_t ADDR_CYC_CNT  = 16'h0008;
    localparam dbg_addr_t ADDR_CYC_SNAP = 16'h0009;

    // Bit positions inside a CMD write
    localparam int CMD_PULSE_BIT = 0;
    localparam int CMD_SNAP_BIT  = 1;
    localparam int CMD_CLEAR_BIT = 2;

    // STATUS word layout: saturation flag above the live done level
    function automatic dbg_word_t status_word(input logic evt_sat, input logic done_lvl);
        return {30'd0, evt_sat, done_lvl};
    endfunction

endpackage

// File: rtl/dbg_scratch_ram.sv
// Scratch word array for the debug-bus responder: synchronous write,
// combinational read, whole array cleared by the asynchronous reset so
// a reset gives a known memory image to the debug host.
module dbg_scratch_ram
    import dbg_bus_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  dbg_word_t     wdata,
    input  logic [AW-1:0] raddr,
    output dbg_word_t     rdata
);

    dbg_word_t mem [DEPTH];

    // Word storage: cleared on reset, one word written per enabled cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dbg_bus_responder.sv
// Debug-bus responder: target end of the taddr/tdin/tdout/twe bus driven
// by the utu debug unit. Provides registered reads of live monitors,
// a control register, snapshot capture, a saturating done-event counter
// and a scratch window.
// Optional feature macro: DBG_RESP_CYCLE_CNT_EN adds a free-running
// 32-bit cycle counter at 0x8 and its snapshot at 0x9.
module dbg_bus_responder
    import dbg_bus_pkg::*;
#(
    parameter int          SCR_DEPTH = 16,
    parameter logic [15:0] SCR_BASE  = 16'h0100,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] taddr,
    input  logic [31:0] tdout,
    input  logic        twe,
    output logic [31:0] tdin,
    input  logic [31:0] mon0,
    input  logic [31:0] mon1,
    input  logic        done_in,
    output logic [31:0] ctrl,
    output logic        cmd_pulse
);

    localparam int SCR_AW = $clog2(SCR_DEPTH);

    logic             scr_hit;
    logic             cmd_wr;
    logic             cmd_snap;
    logic             cmd_clear;
    logic             done_q;
    logic             done_edge;
    logic [CNT_W-1:0] evt_cnt;
    logic             evt_sat;
    dbg_word_t        snap0;
    dbg_word_t        snap1;
    dbg_word_t        scr_rdata;
    dbg_word_t        rd_val;

    // The scratch window is matched on the upper address bits only, so
    // addresses just past the window never alias back into it
    assign scr_hit   = (taddr[15:SCR_AW] == SCR_BASE[15:SCR_AW]);
    assign cmd_wr    = twe && (taddr == ADDR_CMD);
    assign cmd_snap  = cmd_wr && tdout[CMD_SNAP_BIT];
    assign cmd_clear = cmd_wr && tdout[CMD_CLEAR_BIT];
    assign done_edge = done_in && !done_q;
    assign evt_sat   = &evt_cnt;

    dbg_scratch_ram #(
        .DEPTH (SCR_DEPTH),
        .AW    (SCR_AW)
    ) u_scratch (
        .clk   (clk),
        .rstn  (rstn),
        .we    (twe && scr_hit),
        .waddr (taddr[SCR_AW-1:0]),
        .wdata (tdout),
        .raddr (taddr[SCR_AW-1:0]),
        .rdata (scr_rdata)
    );

    // Control register written by the host at ADDR_CTRL
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl <= '0;
        end else if (twe && (taddr == ADDR_CTRL)) begin
            ctrl <= tdout;
        end
    end

    // One strobe cycle per CMD write with bit0 set; held writes give back-to-back strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_pulse <= 1'b0;
        end else begin
            cmd_pulse <= cmd_wr && tdout[CMD_PULSE_BIT];
        end
    end

    // Both monitor words captured on the same edge so they stay coherent
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap0 <= '0;
            snap1 <= '0;
        end else if (cmd_snap) begin
            snap0 <= mon0;
            snap1 <= mon1;
        end
    end

    // Delayed done level for rising-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_in;
        end
    end

    // Saturating done-edge counter; a clear in the same cycle as an edge wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_cnt <= '0;
        end else if (cmd_clear) begin
            evt_cnt <= '0;
        end else if (done_edge && !evt_sat) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

`ifdef DBG_RESP_CYCLE_CNT_EN
    dbg_word_t cyc_cnt;
    dbg_word_t cyc_snap;

    // Free-running cycle counter, wraps naturally, restarted by CMD clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt <= '0;
        end else if (cmd_clear) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    // Cycle count captured together with the monitor snapshot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_snap <= '0;
        end else if (cmd_snap) begin
            cyc_snap <= cyc_cnt;
        end
    end
`endif

    // Read mux over current register values, which makes a same-cycle write invisible to the read
    always_comb begin
        rd_val = '0;
        if (scr_hit) begin
            rd_val = scr_rdata;
        end else begin
            case (taddr)
                ADDR_MON0:     rd_val = mon0;
                ADDR_MON1:     rd_val = mon1;
                ADDR_CTRL:     rd_val = ctrl;
                ADDR_SNAP0:    rd_val = snap0;
                ADDR_SNAP1:    rd_val = snap1;
                ADDR_STATUS:   rd_val = status_word(evt_sat, done_in);
                ADDR_EVT_CNT:  rd_val = 32'(evt_cnt);
`ifdef DBG_RESP_CYCLE_CNT_EN
                ADDR_CYC_CNT:  rd_val = cyc_cnt;
                ADDR_CYC_SNAP: rd_val = cyc_snap;
`endif
                default:       rd_val = '0;
            endcase
        end
    end

    // Registered read data, one cycle after the address is sampled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tdin <= '0;
        end else begin
            tdin <= rd_val;
        end
    end

endmodule

// File: tb/tb_dbg_bus_responder.sv
// Self-checking bench for dbg_bus_responder: a vector table for single
// cycle reads/writes plus directed sequences for strobes, snapshots,
// event counting, saturation, reset and the optional cycle counter
// (DBG_RESP_CYCLE_CNT_EN).
module tb_dbg_bus_responder;
    import dbg_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] taddr;
    logic [31:0] tdout;
    logic        twe;
    logic [31:0] mon0;
    logic [31:0] mon1;
    logic        done_in;
    logic [31:0] tdin;
    logic [31:0] ctrl;
    logic        cmd_pulse;
    logic [31:0] tdin_s;
    logic [31:0] ctrl_s;
    logic        cmd_pulse_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_tdin;
        logic [31:0] exp_ctrl;
        logic        exp_pulse;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    dbg_bus_responder dut (
        .clk       (clk),
        .rstn      (rstn),
        .taddr     (taddr),
        .tdout     (tdout),
        .twe       (twe),
        .tdin      (tdin),
        .mon0      (mon0),
        .mon1      (mon1),
        .done_in   (done_in),
        .ctrl      (ctrl),
        .cmd_pulse (cmd_pulse)
    );

    dbg_bus_responder #(.CNT_W(3)) dut_small (
        .clk       (clk),
        .rstn      (rstn),
        .taddr     (taddr),
        .tdout     (tdout),
        .twe       (twe),
        .tdin      (tdin_s),
        .mon0      (mon0),
        .mon1      (mon1),
        .done_in   (done_in),
        .ctrl      (ctrl_s),
        .cmd_pulse (cmd_pulse_s)
    );

    function automatic vec_t mk(input logic [15:0] a, input logic we, input logic [31:0] d,
                                input logic [31:0] et, input logic [31:0] ec, input logic ep);
        vec_t v;
        v.addr = a; v.we = we; v.wdata = d;
        v.exp_tdin = et; v.exp_ctrl = ec; v.exp_pulse = ep;
        return v;
    endfunction

    task automatic apply_stimulus(input logic [15:0] a, input logic we, input logic [31:0] d);
        taddr = a;
        twe   = we;
        tdout = d;
        @(posedge clk);
        #1;
        twe = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        apply_stimulus(ADDR_MON0, 1'b0, 32'd0);
        done_in = 1'b0;
        apply_stimulus(ADDR_MON0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] c1;

        vecs[0]  = mk(16'h0000, 1'b0, 32'h0,        32'h1234_5678, 32'h0,         1'b0);
        vecs[1]  = mk(16'h0001, 1'b0, 32'h0,        32'hCAFE_F00D, 32'h0,         1'b0);
        vecs[2]  = mk(16'h0002, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0);
        vecs[3]  = mk(16'h0003, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0);
        vecs[4]  = mk(16'h0004, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0);
        vecs[5]  = mk(16'h0005, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0);
        vecs[6]  = mk(16'h0006, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0);
        vecs[7]  = mk(16'h0007, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0);
        vecs[8]  = mk(16'h0002, 1'b1, 32'hA5A5_0001, 32'h0,        32'hA5A5_0001, 1'b0);
        vecs[9]  = mk(16'h0002, 1'b0, 32'h0,        32'hA5A5_0001, 32'hA5A5_0001, 1'b0);
        vecs[10] = mk(16'h0000, 1'b1, 32'h0000_FFFF, 32'h1234_5678, 32'hA5A5_0001, 1'b0);
        vecs[11] = mk(16'h0000, 1'b0, 32'h0,        32'h1234_5678, 32'hA5A5_0001, 1'b0);
        vecs[12] = mk(16'h010F, 1'b1, 32'hDEAD_BEEF, 32'h0,        32'hA5A5_0001, 1'b0);
        vecs[13] = mk(16'h010F, 1'b0, 32'h0,        32'hDEAD_BEEF, 32'hA5A5_0001, 1'b0);
        vecs[14] = mk(16'h010F, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 32'hA5A5_0001, 1'b0);
        vecs[15] = mk(16'h010F, 1'b0, 32'h0,        32'h1111_1111, 32'hA5A5_0001, 1'b0);
        vecs[16] = mk(16'h0110, 1'b0, 32'h0,        32'h0,         32'hA5A5_0001, 1'b0);
        vecs[17] = mk(16'h0110, 1'b1, 32'h5555_5555, 32'h0,        32'hA5A5_0001, 1'b0);
        vecs[18] = mk(16'h0100, 1'b0, 32'h0,        32'h0,         32'hA5A5_0001, 1'b0);
        vecs[19] = mk(16'h00FF, 1'b0, 32'h0,        32'h0,         32'hA5A5_0001, 1'b0);
        vecs[20] = mk(16'h0004, 1'b1, 32'h0000_0999, 32'h0,        32'hA5A5_0001, 1'b0);
        vecs[21] = mk(16'h0004, 1'b0, 32'h0,        32'h0,         32'hA5A5_0001, 1'b0);
        vecs[22] = mk(16'h0003, 1'b1, 32'h0000_0001, 32'h0,        32'hA5A5_0001, 1'b1);
        vecs[23] = mk(16'h0003, 1'b0, 32'h0,        32'h0,         32'hA5A5_0001, 1'b0);

        rstn    = 1'b0;
        taddr   = '0;
        tdout   = '0;
        twe     = 1'b0;
        mon0    = 32'h1234_5678;
        mon1    = 32'hCAFE_F00D;
        done_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_tdin", tdin, 32'h0);
        check_output("reset_ctrl", ctrl, 32'h0);
        check_output("reset_pulse", {31'd0, cmd_pulse}, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata);
            check_output($sformatf("vec%0d_tdin", i), tdin, vecs[i].exp_tdin);
            check_output($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
            check_output($sformatf("vec%0d_pulse", i), {31'd0, cmd_pulse}, {31'd0, vecs[i].exp_pulse});
        end

        mon0 = 32'd7;
        mon1 = 32'd9;
        apply_stimulus(ADDR_CMD, 1'b1, 32'h3);
        check_output("snap_cmd_pulse", {31'd0, cmd_pulse}, 32'h1);
        mon0 = 32'hAA;
        mon1 = 32'hBB;
        apply_stimulus(ADDR_SNAP0, 1'b0, 32'h0);
        check_output("snap_pulse_drop", {31'd0, cmd_pulse}, 32'h0);
        check_output("snap0", tdin, 32'd7);
        apply_stimulus(ADDR_SNAP1, 1'b0, 32'h0);
        check_output("snap1", tdin, 32'd9);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(ADDR_CMD, 1'b1, 32'h1);
            check_output($sformatf("held_pulse%0d", i), {31'd0, cmd_pulse}, 32'h1);
        end
        apply_stimulus(ADDR_CMD, 1'b0, 32'h1);
        check_output("held_pulse_end", {31'd0, cmd_pulse}, 32'h0);

        for (int i = 0; i < 5; i++) pulse_done();
        apply_stimulus(ADDR_EVT_CNT, 1'b0, 32'h0);
        check_output("evt5", tdin, 32'd5);
        check_output("evt5_small", tdin_s, 32'd5);

        for (int i = 0; i < 4; i++) pulse_done();
        apply_stimulus(ADDR_EVT_CNT, 1'b0, 32'h0);
        check_output("evt9", tdin, 32'd9);
        check_output("evt9_small_sat", tdin_s, 32'd7);
        apply_stimulus(ADDR_STATUS, 1'b0, 32'h0);
        check_output("status_low", tdin, 32'h0);
        check_output("status_small_sat", tdin_s, 32'h2);
        done_in = 1'b1;
        apply_stimulus(ADDR_STATUS, 1'b0, 32'h0);
        check_output("status_done", tdin, 32'h1);
        check_output("status_small_done", tdin_s, 32'h3);
        done_in = 1'b0;
        apply_stimulus(ADDR_EVT_CNT, 1'b0, 32'h0);
        check_output("evt10", tdin, 32'd10);
        check_output("evt_small_hold", tdin_s, 32'd7);

        done_in = 1'b1;
        apply_stimulus(ADDR_CMD, 1'b1, 32'h4);
        done_in = 1'b0;
        apply_stimulus(ADDR_EVT_CNT, 1'b0, 32'h0);
        check_output("evt_clear", tdin, 32'd0);
        check_output("evt_clear_small", tdin_s, 32'd0);
        apply_stimulus(ADDR_STATUS, 1'b0, 32'h0);
        check_output("status_clear_small", tdin_s, 32'h0);

        apply_stimulus(ADDR_CMD, 1'b1, 32'h1);
        check_output("pre_reset_pulse", {31'd0, cmd_pulse}, 32'h1);
        rstn = 1'b0;
        #1;
        check_output("async_reset_pulse", {31'd0, cmd_pulse}, 32'h0);
        check_output("async_reset_ctrl", ctrl, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        apply_stimulus(16'h010F, 1'b0, 32'h0);
        check_output("reset_scratch", tdin, 32'h0);
        apply_stimulus(ADDR_SNAP0, 1'b0, 32'h0);
        check_output("reset_snap0", tdin, 32'h0);

`ifdef DBG_RESP_CYCLE_CNT_EN
        apply_stimulus(ADDR_CYC_CNT, 1'b0, 32'h0);
        c1 = tdin;
        for (int i = 0; i < 10; i++) apply_stimulus(ADDR_CYC_CNT, 1'b0, 32'h0);
        check_output("cyc_diff", tdin - c1, 32'd10);
`else
        c1 = 32'h0;
        apply_stimulus(ADDR_CYC_CNT, 1'b0, 32'h0);
        check_output("cyc_unmapped", tdin, c1);
        apply_stimulus(ADDR_CYC_SNAP, 1'b0, 32'h0);
        check_output("cyc_snap_unmapped", tdin, c1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
